axil_reg_bank: RTL
==================

// Module: axil_reg_bank
// PURPOSE
//  Next-generation storage backend for the AXI4-Lite slave: a parametric register bank with
//  per-register access modes (RW, RO, W1C), registered read path and address decode errors.
//  RO registers mirror hardware status. W1C registers latch hardware event pulses and drive an
//  interrupt. Read and write data are returned one cycle after request, with AXI-coded responses.
// PARAMETERS
//  DATA_WIDTH  32       register width in bits; must be a multiple of 8
//  NUM_REGS    16       number of implemented registers (>=2)
//  ADDR_WIDTH  5        word-address width; must be >= $clog2(NUM_REGS), can decode past NUM_REGS
//  RO_MASK     'h0      NUM_REGS bits; bit i=1 -> reg i read-only, value = hw_status slice i
//  W1C_MASK    'h0      NUM_REGS bits; bit i=1 -> reg i write-1-to-clear; RO_MASK wins on overlap
// PORTS
//  clk            in   1                       clock, all logic on rising edge
//  rst_n          in   1                       asynchronous reset, active low
//  wr_en          in   1                       write request, single-cycle qualifier
//  wr_addr        in   ADDR_WIDTH              write word address
//  wr_data        in   DATA_WIDTH              write data
//  wr_strb        in   DATA_WIDTH/8            byte-lane write enables
//  wr_resp_valid  out  1                       one-cycle pulse, write response available
//  wr_resp        out  2                       00 OKAY, 10 SLVERR, 11 DECERR
//  rd_en          in   1                       read request, single-cycle qualifier
//  rd_addr        in   ADDR_WIDTH              read word address
//  rd_valid       out  1                       one-cycle pulse, rd_data/rd_resp valid
//  rd_data        out  DATA_WIDTH              read data
//  rd_resp        out  2                       00 OKAY, 11 DECERR
//  hw_status      in   NUM_REGS*DATA_WIDTH     RO register sources, slice i -> reg i
//  hw_set         in   NUM_REGS*DATA_WIDTH     W1C set pulses, slice i -> reg i, ignored elsewhere
//  reg_q          out  NUM_REGS*DATA_WIDTH     current RW/W1C register contents, RO slices = 0
//  irq            out  1                       OR-reduce of all W1C register bits
// BEHAVIOUR
//  Reset (async assert, sync release): all registers 0; wr_resp_valid=0, wr_resp=00,
//    rd_valid=0, rd_data=0, rd_resp=00, irq=0. In-flight responses are discarded, no pulse after release.
//  Write, wr_en sampled at edge N; wr_resp_valid=1 during cycle N+1 only; back-to-back writes allowed.
//   - wr_addr >= NUM_REGS: no state change, wr_resp=11.
//   - RO reg: no state change, wr_resp=10.
//   - RW reg: each lane k with wr_strb[k]=1 takes wr_data[8k+7:8k] at edge N; wr_resp=00.
//   - W1C reg: within strobed lanes, bits with wr_data=1 are cleared, others held; wr_resp=00.
//   - wr_strb=0 to a valid RW/W1C reg: no change, wr_resp=00.
//  W1C set: every edge, reg_i |= hw_set slice i. Same-edge set and W1C clear on the same bit -> set wins.
//  Read, rd_en sampled at edge N; rd_valid=1 during cycle N+1 only; back-to-back reads allowed.
//   - rd_data is the reg value before edge N updates. Same-cycle write to the same addr returns OLD data.
//   - RO reg: rd_data = hw_status slice sampled at edge N.
//   - rd_addr >= NUM_REGS: rd_data=0, rd_resp=11; otherwise rd_resp=00.
//   - rd_data/rd_resp hold their last value while rd_valid=0.
//  Read and write ports are independent; both may fire every cycle.
//  irq is driven from register flops only: it rises the cycle after the setting edge, and falls
//    the cycle after the clearing edge.
//  Width rules: ADDR_WIDTH compare is unsigned. No partial lanes. Generic over DATA_WIDTH/8 lanes.
// TESTING (DATA_WIDTH=32, NUM_REGS=16, ADDR_WIDTH=5, RO_MASK=16'h0002, W1C_MASK=16'h0004)
//  1 wr reg0 0xDEADBEEF strb 0xF, then wr 0x000000AA strb 0x1, rd reg0
//    -> resp 00, data 0xDEADBEAA, rd_valid exactly 1 cycle after rd_en.
//  2 hw_status[1]=0x12345678, rd reg1 -> 0x12345678/00; wr reg1 0xFFFFFFFF -> wr_resp 10, reg unchanged.
//  3 pulse hw_set[2]=0x5 -> irq=1 next cycle; wr reg2 0x1 -> reg2=0x4, irq=1; wr reg2 0x4 -> reg2=0, irq=0.
//  4 same edge hw_set[2]=0x1 and wr reg2 0x1 -> reg2 bit0 stays 1; same-edge wr/rd reg3 -> read returns old value.
//  5 wr/rd addr 16 and 31 -> wr_resp 11, rd_resp 11, rd_data 0, no register changes in reg_q.
//  6 assert rst_n=0 during a cycle with wr_en, rd_en and pending valids
//    -> all outputs 0 immediately; no valid pulse after release.

Source files
------------

// File: rtl/axil_reg_bank.sv
// Parametric register bank behind an AXI4-Lite slave: RW, RO and W1C registers,
// with registered read and write responses and an interrupt fed by the W1C bits.
module axil_reg_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  output logic                           wr_resp_valid,
  output logic [1:0]                     wr_resp,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic                           rd_valid,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [1:0]                     rd_resp,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic                           irq
);

  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
  logic [DATA_WIDTH-1:0]          strb_mask;
  logic [DATA_WIDTH-1:0]          cur, nxt;
  logic                           hit;
  logic                           irq_d;
  logic [1:0]                     wr_resp_c, rd_resp_c;
  logic [DATA_WIDTH-1:0]          rd_data_c;

  // Only some slices of the hardware buses are meaningful for a given mask set.
  logic unused_hw;
  assign unused_hw = &{1'b0, hw_status, hw_set};

  // Expand byte strobes into a bit mask.
  always_comb begin
    strb_mask = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      strb_mask[k*8 +: 8] = {8{wr_strb[k]}};
    end
  end

  // Next register state; RO flops stay at zero so reg_q reports 0 for them.
  always_comb begin
    regs_d = regs_q;
    irq_d  = 1'b0;
    cur    = '0;
    nxt    = '0;
    hit    = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      cur = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
      hit = wr_en && (32'(wr_addr) == 32'(i));
      if (RO_MASK[i]) begin
        nxt = '0;
      end else if (W1C_MASK[i]) begin
        // Hardware set is OR'd after the clear so a same-edge set wins.
        nxt = (cur & ~(hit ? (strb_mask & wr_data) : '0)) |
              hw_set[i*DATA_WIDTH +: DATA_WIDTH];
        irq_d = irq_d | (|nxt);
      end else begin
        nxt = hit ? ((cur & ~strb_mask) | (wr_data & strb_mask)) : cur;
      end
      regs_d[i*DATA_WIDTH +: DATA_WIDTH] = nxt;
    end
  end

  // Write response decode.
  always_comb begin
    wr_resp_c = RESP_OKAY;
    if (32'(wr_addr) >= NUM_REGS) begin
      wr_resp_c = RESP_DECERR;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if ((32'(wr_addr) == 32'(i)) && RO_MASK[i]) wr_resp_c = RESP_SLVERR;
      end
    end
  end

  // Read mux over pre-update register values or live status for RO slots.
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = (32'(rd_addr) >= NUM_REGS) ? RESP_DECERR : RESP_OKAY;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (32'(rd_addr) == 32'(i)) begin
        rd_data_c = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH]
                               : regs_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q        <= '0;
      irq           <= 1'b0;
      wr_resp_valid <= 1'b0;
      wr_resp       <= RESP_OKAY;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      rd_resp       <= RESP_OKAY;
    end else begin
      regs_q        <= regs_d;
      irq           <= irq_d;
      wr_resp_valid <= wr_en;
      rd_valid      <= rd_en;
      if (wr_en) wr_resp <= wr_resp_c;
      if (rd_en) begin
        rd_data <= rd_data_c;
        rd_resp <= rd_resp_c;
      end
    end
  end

  assign reg_q = regs_q;

endmodule
